fp32_add_arbiter: RTL
=====================

// Module: fp32_add_arbiter
// PURPOSE
//  Shares one pipelined FP32 adder (e.g. adder32, latency 1) among NREQ requesters.
//  Each cycle, a round-robin arbiter grants at most one request and drives its A/B onto the adder.
//  A tag pipeline tracks the in-flight operation and routes each sum back to its requester ADD_LAT cycles later.
//  Sits between SIGMA reduction/accumulation clients and the single shared FP adder instance.
// PARAMETERS
//  NREQ     4   number of requesters (2..16)
//  IDW      2   requester index width, = clog2(NREQ)
//  ADD_LAT  1   adder input-to-output latency in clk cycles (>=1); must match the instanced adder
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, synchronous, active-high
//  hold         in   1        1 = issue no new operations (in-flight ops still complete)
//  req_valid    in   NREQ     per-requester operation valid
//  req_ready    out  NREQ     per-requester accept (one-hot or zero)
//  req_a        in   NREQ*32  operand A, requester i in bits [32i+31:32i]
//  req_b        in   NREQ*32  operand B, same packing
//  resp_valid   out  NREQ     one-hot: the sum for requester i is on resp_data this cycle
//  resp_data    out  32       FP32 sum
//  add_a        out  32       to adder A
//  add_b        out  32       to adder B
//  add_o        in   32       from adder O
//  busy         out  1        any operation in flight
//  issue_count  out  32       operations issued since reset; wraps 0xFFFFFFFF->0
// BEHAVIOUR
//  Reset (rst=1 at posedge): rr_ptr=0, all tag stages invalid, issue_count=0.
//   Any in-flight result is discarded: no resp_valid for it after reset.
//  Arbitration (combinational, per cycle):
//   - Scan req_valid starting at index rr_ptr, ascending modulo NREQ; the first set bit is the grant g.
//   - No grant if hold=1, rst=1, or req_valid==0.
//  Handshake: req_ready = onehot(g) when a grant exists, else 0.
//   - req_ready may depend on req_valid.
//   - A transfer occurs when req_valid[i] & req_ready[i].
//   - Requesters must hold A/B stable while valid and not ready.
//  Adder drive:
//   - Grant present: add_a/add_b = req_a/req_b slice g.
//   - No grant: add_a/add_b = 32'h0.
//  On a transfer at posedge:
//   - rr_ptr <= (g+1) mod NREQ.
//   - issue_count <= issue_count+1.
//   - Tag stage 0 <= {1, g}.
//   - With no transfer, rr_ptr holds and stage 0 <= invalid.
//  Tag pipeline: ADD_LAT stages {v, id[IDW-1:0]}, shifting every cycle; it never stalls.
//  Response (combinational from last stage):
//   - resp_valid[id] = v of last stage.
//   - resp_data = add_o when v=1, else 32'h0.
//   - Requesters must accept the response; there is no backpressure.
//  Latency and throughput:
//   - Transfer in cycle t -> resp_valid in cycle t+ADD_LAT.
//   - Throughput is 1 op/cycle aggregate.
//   - A single requester valid every cycle is granted every cycle.
//  busy = OR of all tag-stage v bits.
//  Simultaneous events:
//   - A requester may issue and receive a response in the same cycle.
//   - hold rising mid-stream blocks only new grants; ops already in flight still respond.
//  No FP special-case handling here; NaN/Inf/zero semantics belong to the adder.
// TESTING
//  1) Req0 only: A=0x3F800000, B=0x40000000 at t -> req_ready=0001 at t; resp_valid=0001, resp_data=0x40400000 at t+1.
//  2) All 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; resp ids follow 1 cycle later; issue_count=8.
//  3) rr_ptr=2, only req0 and req3 valid -> grant 3, then 0; req1/req2 never get ready.
//  4) hold=1 with all valid for 3 cycles -> req_ready=0, add_a=add_b=0; the op issued before hold still responds; busy drops after ADD_LAT.
//  5) rst pulse the cycle after an issue -> no resp_valid for that op; rr_ptr=0, issue_count=0, busy=0.
//  6) Force issue_count=0xFFFFFFFF, then issue one op -> issue_count=0; ADD_LAT=3 build: resp arrives at t+3 with the correct one-hot id.

Source files
------------

// File: rtl/fp32_add_arbiter.sv
// Round-robin front end that shares one pipelined FP32 adder among NREQ requesters.
// A tag pipeline that never stalls carries each sum back to the requester that issued it.
module fp32_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_o,
  output logic                 busy,
  output logic [31:0]          issue_count
);

  logic [IDW-1:0]  r_rr_ptr;
  logic [31:0]     r_issue_count;
  logic [ADD_LAT-1:0] r_tag_v;
  logic [IDW-1:0]  r_tag_id [ADD_LAT];

  logic            w_grant_vld;
  logic [IDW-1:0]  w_grant_id;
  logic [IDW-1:0]  w_scan_idx;
  logic            w_last_v;

  // Descending scan so the final assignment wins: that is the first hit at or after r_rr_ptr.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_scan_idx  = '0;
    if (!hold && !rst) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        w_scan_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
        if (req_valid[w_scan_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = w_scan_idx;
        end
      end
    end
  end

  assign req_ready = w_grant_vld ? (NREQ'(1) << w_grant_id) : '0;
  assign add_a     = w_grant_vld ? req_a[32*int'(w_grant_id) +: 32] : 32'h0;
  assign add_b     = w_grant_vld ? req_b[32*int'(w_grant_id) +: 32] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_issue_count <= '0;
      r_tag_v       <= '0;
    end else begin
      if (w_grant_vld) begin
        r_rr_ptr      <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);
        r_issue_count <= r_issue_count + 32'd1;
      end
      r_tag_v[0] <= w_grant_vld;
      for (int i = 1; i < ADD_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
      end
    end
  end

  // NOTE: tag ids are a reset-free shift register; only the valid bits need a defined reset value.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_grant_id;
    for (int i = 1; i < ADD_LAT; i++) begin
      r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  // A result still in flight when reset arrives is dropped, even in the reset cycle itself.
  assign w_last_v    = r_tag_v[ADD_LAT-1] & ~rst;
  assign resp_valid  = w_last_v ? (NREQ'(1) << r_tag_id[ADD_LAT-1]) : '0;
  assign resp_data   = w_last_v ? add_o : 32'h0;
  assign busy        = |r_tag_v;
  assign issue_count = r_issue_count;

endmodule
